// File: rtl/voq_fifo.sv
// voq_fifo: N_CH independent circular-buffer queues, one push and one pop per cycle, steered by channel index.
// Latency: 1 cycle from rd_en to rd_data/rd_valid; flags and count follow the registered occupancy.
// Backpressure: producer watches full, consumer watches empty; violations are dropped and flagged sticky in ovf/udf.
// Optional feature macro: VOQ_AFULL_EN adds AF_LEVEL and the per-channel almost_full output.
module voq_fifo #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 16,
  parameter int N_CH   = 4,
`ifdef VOQ_AFULL_EN
  parameter int AF_LEVEL = 12,
`endif
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CW-1:0]            wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [CW-1:0]            rd_ch,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [N_CH-1:0]          full,
  output logic [N_CH-1:0]          empty,
  output logic [N_CH*(AW+1)-1:0]   count,
`ifdef VOQ_AFULL_EN
  output logic [N_CH-1:0]          almost_full,
`endif
  output logic [N_CH-1:0]          ovf,
  output logic [N_CH-1:0]          udf,
  input  logic                     err_clr
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
`ifdef VOQ_AFULL_EN
  localparam logic [AW:0]   AF_CNT   = (AW+1)'(AF_LEVEL);
`endif

  // Storage is deliberately not reset; only written words are ever read back.
  logic [DATA_W-1:0] mem_q [N_CH][DEPTH];

  logic [AW-1:0]     wr_ptr_q [N_CH];
  logic [AW-1:0]     wr_ptr_d [N_CH];
  logic [AW-1:0]     rd_ptr_q [N_CH];
  logic [AW-1:0]     rd_ptr_d [N_CH];
  logic [AW:0]       cnt_q    [N_CH];
  logic [AW:0]       cnt_d    [N_CH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [N_CH-1:0]   udf_q, udf_d;

  logic              push_ok, pop_ok;
  logic [N_CH-1:0]   push_vec, pop_vec;

  // Accept decisions: pop judged on pre-cycle count (no bypass); a full channel
  // still takes a push when the same channel is popped this cycle.
  always_comb begin
    pop_ok   = rd_en && (cnt_q[rd_ch] != '0);
    push_ok  = wr_en && ((cnt_q[wr_ch] != FULL_CNT) || (pop_ok && (rd_ch == wr_ch)));
    push_vec = '0;
    pop_vec  = '0;
    if (push_ok) push_vec[wr_ch] = 1'b1;
    if (pop_ok)  pop_vec[rd_ch]  = 1'b1;
  end

  // Next-state for pointers, occupancy, read register and sticky error flags.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      if (push_vec[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
      if (pop_vec[c])  rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
      case ({push_vec[c], pop_vec[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
    rd_valid_d = pop_ok;
    rd_data_d  = pop_ok ? mem_q[rd_ch][rd_ptr_q[rd_ch]] : rd_data_q;
    // A new violation wins over a concurrent clear.
    ovf_d = err_clr ? '0 : ovf_q;
    udf_d = err_clr ? '0 : udf_q;
    if (wr_en && !push_ok) ovf_d[wr_ch] = 1'b1;
    if (rd_en && !pop_ok)  udf_d[rd_ch] = 1'b1;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= '0;
      udf_q      <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage write; a same-slot pop in this cycle still reads the old word.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ch][wr_ptr_q[wr_ch]] <= wr_data;
  end

  // Status flags decoded from registered occupancy.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      full[c]                  = (cnt_q[c] == FULL_CNT);
      empty[c]                 = (cnt_q[c] == '0);
      count[c*(AW+1) +: AW+1]  = cnt_q[c];
`ifdef VOQ_AFULL_EN
      almost_full[c]           = (cnt_q[c] >= AF_CNT);
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_voq_fifo.sv
// Directed bench for voq_fifo with a read-data scoreboard and a negedge monitor.
module tb_voq_fifo;
  localparam int DATA_W = 33;
  localparam int DEPTH  = 16;
  localparam int N_CH   = 4;
  localparam int AW     = 4;
  localparam int CW     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   wr_en = 1'b0;
  logic [CW-1:0]          wr_ch = '0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic                   rd_en = 1'b0;
  logic [CW-1:0]          rd_ch = '0;
  logic                   err_clr = 1'b0;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;
  logic [N_CH-1:0]        full, empty, ovf, udf;
  logic [N_CH*(AW+1)-1:0] count;
`ifdef VOQ_AFULL_EN
  logic [N_CH-1:0]        almost_full;
`endif

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  voq_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH)
`ifdef VOQ_AFULL_EN
    , .AF_LEVEL(12)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
`ifdef VOQ_AFULL_EN
    .almost_full(almost_full),
`endif
    .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW:0] cnt_of(input int c);
    return count[c*(AW+1) +: AW+1];
  endfunction

  // Monitor: every presented read word is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 64'(rd_data), 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [CW-1:0] wc, input logic [DATA_W-1:0] wd,
                     input logic re, input logic [CW-1:0] rc, input logic ec);
    wr_en = we; wr_ch = wc; wr_data = wd;
    rd_en = re; rd_ch = rc; err_clr = ec;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DATA_W-1:0] d);
    cyc(1'b1, c, d, 1'b0, '0, 1'b0);
  endtask

  task automatic pop_exp(input logic [CW-1:0] c, input logic [DATA_W-1:0] d);
    exp_q.push_back(d);
    cyc(1'b0, '0, '0, 1'b1, c, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int maxc;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 64'(empty), 64'hF);
    check("rst_full", 64'(full), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_rd_valid", 64'(rd_valid), 64'h0);
    check("rst_ovf_udf", 64'({ovf, udf}), 64'h0);
    rst_n = 1'b1;

    // Reset mid-traffic on ch2
    for (int i = 0; i < 5; i++) push(2'd2, 33'h200 + 33'(i));
    check("ch2_count5", 64'(cnt_of(2)), 64'd5);
    pop_exp(2'd2, 33'h200);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_empty", 64'(empty), 64'hF);
    check("midrst_count", 64'(count), 64'h0);
    check("midrst_rd_valid", 64'(rd_valid), 64'h0);
    #1 rst_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b1, 2'd2, 1'b0);
    check("post_rst_udf2", 64'(udf), 64'h4);
    check("post_rst_rd_valid", 64'(rd_valid), 64'h0);
    clr();
    check("udf_cleared", 64'(udf), 64'h0);

    // Order and wrap on ch1
    maxc = 0;
    for (int i = 0; i < 10; i++) begin
      push(2'd1, 33'h1_0000_0000 + 33'(i));
      if (int'(cnt_of(1)) > maxc) maxc = int'(cnt_of(1));
    end
    for (int k = 0; k < 30; k++) begin
      exp_q.push_back(33'h1_0000_0000 + 33'(k));
      cyc(1'b1, 2'd1, 33'h1_0000_0000 + 33'(10 + k), 1'b1, 2'd1, 1'b0);
      if (int'(cnt_of(1)) > maxc) maxc = int'(cnt_of(1));
    end
    for (int k = 30; k < 40; k++) pop_exp(2'd1, 33'h1_0000_0000 + 33'(k));
    check("wrap_max_count", 64'(maxc), 64'd10);
    check("wrap_final_empty1", 64'(empty[1]), 64'h1);

    // Full boundary on ch0
    for (int i = 0; i < 16; i++) push(2'd0, 33'h300 + 33'(i));
    check("full0", 64'(full), 64'h1);
    check("count0_16", 64'(cnt_of(0)), 64'd16);
    push(2'd0, 33'h3FF);
    check("ovf0_set", 64'(ovf), 64'h1);
    check("count0_after_drop", 64'(cnt_of(0)), 64'd16);
    clr();
    exp_q.push_back(33'h300);
    cyc(1'b1, 2'd0, 33'h310, 1'b1, 2'd0, 1'b0);
    check("full_pushpop_count", 64'(cnt_of(0)), 64'd16);
    check("full_pushpop_no_ovf", 64'(ovf), 64'h0);
    for (int i = 1; i < 17; i++) pop_exp(2'd0, 33'h300 + 33'(i));
    check("drain_empty0", 64'(empty[0]), 64'h1);

    // Empty boundary on ch3
    cyc(1'b1, 2'd3, 33'h400, 1'b1, 2'd3, 1'b0);
    check("eb_rd_valid", 64'(rd_valid), 64'h0);
    check("eb_udf3", 64'(udf), 64'h8);
    check("eb_count3", 64'(cnt_of(3)), 64'd1);
    pop_exp(2'd3, 33'h400);
    check("eb_next_rd_valid", 64'(rd_valid), 64'h1);
    clr();

    // Channel isolation
    for (int i = 0; i < 8; i++) begin
      push(2'd0, 33'hA);
      push(2'd3, 33'hB);
    end
    for (int i = 0; i < 8; i++) pop_exp(2'd3, 33'hB);
    check("iso_count0", 64'(cnt_of(0)), 64'd8);
    check("iso_count3", 64'(cnt_of(3)), 64'd0);
    for (int i = 0; i < 8; i++) push(2'd0, 33'hA);
    check("iso_full0", 64'(full[0]), 64'h1);
    cyc(1'b1, 2'd0, 33'hC, 1'b0, '0, 1'b1);
    check("clr_vs_ovf", 64'(ovf), 64'h1);
    clr();
    check("ovf_cleared", 64'(ovf), 64'h0);

`ifdef VOQ_AFULL_EN
    // Almost-full threshold on ch2
    for (int i = 0; i < 11; i++) push(2'd2, 33'h500 + 33'(i));
    check("af2_at11", 64'(almost_full[2]), 64'h0);
    push(2'd2, 33'h50B);
    check("af2_at12", 64'(almost_full[2]), 64'h1);
    pop_exp(2'd2, 33'h500);
    check("af2_after_pop", 64'(almost_full[2]), 64'h0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
